rggen_bus_arbiter: RTL and testbench

Shares one register-block bus (`rggen_bus_if` master side) between `HOSTS` host interface adapters, each of which drives a `rggen_bus_if`-style request. Each transfer is granted to one host with round-robin fairness and held until the register block returns `done`. The block sits between the per-protocol host adapters and the register block decoder. An optional watchdog terminates transfers the register block never completes.

---
 rtl/rggen_rtl_pkg.sv | 22 ++
 rtl/rggen_round_robin_selector.sv | 37 +++
 rtl/rggen_bus_arbiter.sv | 160 ++++++++++++++++
 tb/tb_rggen_bus_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rggen_rtl_pkg.sv
// Shared register-bus definitions for the rggen RTL slice.
//   rggen_direction          : READ/WRITE encoding of a register-bus transfer
//   RGGEN_* status constants : two-bit response status, bit 1 = error
//   rggen_bus_arbiter_state  : state encoding of rggen_bus_arbiter
package rggen_rtl_pkg;

  typedef enum logic {
    RGGEN_READ  = 1'b0,
    RGGEN_WRITE = 1'b1
  } rggen_direction;

  localparam logic [1:0] RGGEN_OKAY         = 2'b00;
  localparam logic [1:0] RGGEN_EXOKAY       = 2'b01;
  localparam logic [1:0] RGGEN_SLAVE_ERROR  = 2'b10;
  localparam logic [1:0] RGGEN_DECODE_ERROR = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } rggen_bus_arbiter_state;

endpackage

// File: rtl/rggen_round_robin_selector.sv
// Combinational round-robin pick.
//   request : one bit per requester
//   last    : index of the previous winner; the scan starts at last+1
//   found   : at least one request is set
//   index   : first requester at or after last+1, wrapping modulo HOSTS
//             (last itself is reached only when nobody else requests)
module rggen_round_robin_selector
  import rggen_rtl_pkg::*;
#(
  parameter int HOSTS       = 2,
  parameter int INDEX_WIDTH = (HOSTS > 1) ? $clog2(HOSTS) : 1
)(
  input  logic [HOSTS-1:0]       request,
  input  logic [INDEX_WIDTH-1:0] last,
  output logic                   found,
  output logic [INDEX_WIDTH-1:0] index
);

  int unsigned            candidate;
  logic [INDEX_WIDTH-1:0] candidate_index;

  always_comb begin
    found           = 1'b0;
    index           = '0;
    candidate       = 0;
    candidate_index = '0;
    for (int i = 1; i <= HOSTS; i++) begin
      candidate       = (int'(last) + i) % HOSTS;
      candidate_index = INDEX_WIDTH'(candidate);
      if (!found && request[candidate_index]) begin
        found = 1'b1;
        index = candidate_index;
      end
    end
  end

endmodule

// File: rtl/rggen_bus_arbiter.sv
// Round-robin arbiter sharing one register-block bus between HOSTS host
// adapters. A grant is held from the first BUSY cycle until bus_done.
//
// Optional feature: define RGGEN_BUS_ARBITER_TIMEOUT_EN to compile in a
// watchdog that force-completes a transfer with SLAVE_ERROR status after
// TIMEOUT BUSY cycles without bus_done.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   host_request        : per-host request, held until that host's host_done
//   host_address/direction/write_data/write_strobe : per-host transfer fields
//   host_done           : one-cycle completion pulse to the granted host
//   host_read_data      : read data broadcast (0 outside a completion)
//   host_status         : status broadcast (0 outside a completion)
//   bus_request         : high for every BUSY cycle
//   bus_address/direction/write_data/write_strobe : fields of the granted host
//   bus_done            : completion from the register block
//   bus_read_data       : read data from the register block
//   bus_status          : status from the register block
//   debug_state         : current arbiter state
//
// Handshake: a transfer is offered by bus_request=1 and accepted by
// bus_done=1 in the same cycle; bus_request holds with stable fields until
// then, and host_done mirrors that accepting cycle back to the winner.
module rggen_bus_arbiter
  import rggen_rtl_pkg::*;
#(
  parameter int HOSTS         = 2,
  parameter int ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH     = 32,
  parameter int TIMEOUT       = 255
)(
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [HOSTS-1:0]                        host_request,
  input  logic [HOSTS-1:0][ADDRESS_WIDTH-1:0]     host_address,
  input  rggen_direction [HOSTS-1:0]              host_direction,
  input  logic [HOSTS-1:0][BUS_WIDTH-1:0]         host_write_data,
  input  logic [HOSTS-1:0][BUS_WIDTH/8-1:0]       host_write_strobe,
  output logic [HOSTS-1:0]                        host_done,
  output logic [BUS_WIDTH-1:0]                    host_read_data,
  output logic [1:0]                              host_status,
  output logic                                    bus_request,
  output logic [ADDRESS_WIDTH-1:0]                bus_address,
  output rggen_direction                          bus_direction,
  output logic [BUS_WIDTH-1:0]                    bus_write_data,
  output logic [BUS_WIDTH/8-1:0]                  bus_write_strobe,
  input  logic                                    bus_done,
  input  logic [BUS_WIDTH-1:0]                    bus_read_data,
  input  logic [1:0]                              bus_status,
  output rggen_bus_arbiter_state                  debug_state
);

  localparam int INDEX_WIDTH = $clog2(HOSTS);

  if (HOSTS < 2 || HOSTS > 8) begin : g_hosts_range
    $error("rggen_bus_arbiter: HOSTS must be in 2..8");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_timeout_range
    $error("rggen_bus_arbiter: TIMEOUT must be in 1..65535");
  end

  rggen_bus_arbiter_state state;
  rggen_bus_arbiter_state state_next;
  logic [INDEX_WIDTH-1:0] grant;
  logic [INDEX_WIDTH-1:0] last;
  logic                   select_found;
  logic [INDEX_WIDTH-1:0] select_index;
  logic                   timeout;

  rggen_round_robin_selector #(
    .HOSTS       (HOSTS),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_selector (
    .request (host_request),
    .last    (last),
    .found   (select_found),
    .index   (select_index)
  );

`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
  localparam int TIMER_WIDTH = $clog2(TIMEOUT + 1);

  logic [TIMER_WIDTH-1:0] timer;

  // Held at zero through IDLE so every BUSY period starts counting from 0;
  // the comparison value makes bus_request last exactly TIMEOUT cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (state == IDLE) begin
      timer <= '0;
    end else if (!bus_done) begin
      timer <= timer + 1'b1;
    end
  end

  assign timeout = (state == BUSY) && !bus_done &&
                   (timer == TIMER_WIDTH'(TIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  // Reset leaves last at HOSTS-1 so the first scan starts at host 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      last  <= INDEX_WIDTH'(HOSTS - 1);
    end else begin
      state <= state_next;
      if (state == IDLE && select_found) begin
        grant <= select_index;
        last  <= select_index;
      end
    end
  end

  // Transfer fields follow grant at all times; only bus_request qualifies them.
  always_comb begin
    bus_address      = host_address[grant];
    bus_direction    = host_direction[grant];
    bus_write_data   = host_write_data[grant];
    bus_write_strobe = host_write_strobe[grant];
  end

  always_comb begin
    state_next     = state;
    bus_request    = 1'b0;
    host_done      = '0;
    host_read_data = '0;
    host_status    = RGGEN_OKAY;
    case (state)
      IDLE: begin
        if (select_found) begin
          state_next = BUSY;
        end
      end
      BUSY: begin
        // A dropped host_request does not cancel the grant: the register
        // block has already seen the transfer and must be allowed to finish.
        bus_request = 1'b1;
        if (bus_done) begin
          host_done[grant] = 1'b1;
          host_read_data   = bus_read_data;
          host_status      = bus_status;
          state_next       = IDLE;
        end else if (timeout) begin
          host_done[grant] = 1'b1;
          host_status      = RGGEN_SLAVE_ERROR;
          state_next       = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign debug_state = state;

endmodule

// File: tb/tb_rggen_bus_arbiter.sv
module tb_rggen_bus_arbiter;
  import rggen_rtl_pkg::*;

  localparam int HOSTS = 2;
  localparam int AW    = 16;
  localparam int BW    = 32;
  localparam int SW    = BW / 8;
  localparam int HW    = $clog2(HOSTS);
`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
  localparam int TIMEOUT = 8;
`else
  localparam int TIMEOUT = 255;
`endif

  logic                         clk = 1'b0;
  logic                         rst_n;
  logic [HOSTS-1:0]             host_request;
  logic [HOSTS-1:0][AW-1:0]     host_address;
  rggen_direction [HOSTS-1:0]   host_direction;
  logic [HOSTS-1:0][BW-1:0]     host_write_data;
  logic [HOSTS-1:0][SW-1:0]     host_write_strobe;
  logic [HOSTS-1:0]             host_done;
  logic [BW-1:0]                host_read_data;
  logic [1:0]                   host_status;
  logic                         bus_request;
  logic [AW-1:0]                bus_address;
  rggen_direction               bus_direction;
  logic [BW-1:0]                bus_write_data;
  logic [SW-1:0]                bus_write_strobe;
  logic                         bus_done;
  logic [BW-1:0]                bus_read_data;
  logic [1:0]                   bus_status;
  rggen_bus_arbiter_state       debug_state;

  int checks = 0;
  int errors = 0;
  int rr_last = HOSTS - 1;          // reference model: previous winner
  logic [HW-1:0] exp_q[$];          // scoreboard: expected winners in order

  rggen_bus_arbiter #(
    .HOSTS         (HOSTS),
    .ADDRESS_WIDTH (AW),
    .BUS_WIDTH     (BW),
    .TIMEOUT       (TIMEOUT)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .host_request      (host_request),
    .host_address      (host_address),
    .host_direction    (host_direction),
    .host_write_data   (host_write_data),
    .host_write_strobe (host_write_strobe),
    .host_done         (host_done),
    .host_read_data    (host_read_data),
    .host_status       (host_status),
    .bus_request       (bus_request),
    .bus_address       (bus_address),
    .bus_direction     (bus_direction),
    .bus_write_data    (bus_write_data),
    .bus_write_strobe  (bus_write_strobe),
    .bus_done          (bus_done),
    .bus_read_data     (bus_read_data),
    .bus_status        (bus_status),
    .debug_state       (debug_state)
  );

  // ---------------- clock / safety bound ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "time limit");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first requester after the previous winner, wrapping.
  function automatic int rr_pick(input logic [HOSTS-1:0] req, input int after);
    int idx;
    logic [HW-1:0] bit_idx;
    for (int k = 1; k <= HOSTS; k++) begin
      idx = (after + k) % HOSTS;
      bit_idx = idx[HW-1:0];
      if (req[bit_idx]) return idx;
    end
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic randomize_hosts();
    for (int h = 0; h < HOSTS; h++) begin
      host_address[h]      = AW'($urandom);
      host_direction[h]    = rggen_direction'($urandom_range(0, 1));
      host_write_data[h]   = $urandom;
      host_write_strobe[h] = SW'($urandom);
    end
  endtask

  // Called just after a posedge with the arbiter in IDLE and requests
  // already presented. Returns just after the posedge following host_done.
  task automatic do_transfer(input int delay, input logic [BW-1:0] rdata,
                             input logic [1:0] st, input bit drop_early,
                             input bit release_after);
    int w;
    logic [HW-1:0] wi;
    logic [HW-1:0] obs_w;
    logic [HW-1:0] exp_w;
    logic [HOSTS-1:0] onehot;
    w = rr_pick(host_request, rr_last);
    if (w < 0) w = rr_last;          // callers always present a request
    rr_last = w;
    wi = w[HW-1:0];
    exp_q.push_back(wi);
    onehot = '0;
    onehot[wi] = 1'b1;

    @(negedge clk);
    check("idle_bus_request", 64'(bus_request), 64'd0);
    check("idle_host_done", 64'(host_done), 64'd0);
    check("idle_read_data", 64'(host_read_data), 64'd0);
    check("idle_status", 64'(host_status), 64'd0);
    check("idle_state", 64'(debug_state), 64'(IDLE));

    for (int c = 1; c <= delay; c++) begin
      @(posedge clk); #1;
      if (c == 1 && drop_early) host_request[wi] = 1'b0;
      if (c == delay) begin
        bus_done      = 1'b1;
        bus_read_data = rdata;
        bus_status    = st;
      end
      @(negedge clk);
      check("bus_request", 64'(bus_request), 64'd1);
      check("bus_address", 64'(bus_address), 64'(host_address[wi]));
      check("bus_direction", 64'(bus_direction), 64'(host_direction[wi]));
      check("bus_write_data", 64'(bus_write_data), 64'(host_write_data[wi]));
      check("bus_write_strobe", 64'(bus_write_strobe), 64'(host_write_strobe[wi]));
      if (c < delay) begin
        check("early_host_done", 64'(host_done), 64'd0);
      end else begin
        check("host_done", 64'(host_done), 64'(onehot));
        check("host_read_data", 64'(host_read_data), 64'(rdata));
        check("host_status", 64'(host_status), 64'(st));
        obs_w = '0;
        for (int h = 0; h < HOSTS; h++) if (host_done[h]) obs_w = HW'(h);
        exp_w = exp_q.pop_front();
        check("grant_order", 64'(obs_w), 64'(exp_w));
      end
    end

    @(posedge clk); #1;
    bus_done      = 1'b0;
    bus_read_data = $urandom | 32'h1;
    bus_status    = 2'($urandom_range(1, 3));
    if (release_after) host_request[wi] = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n_high;
    logic [HOSTS-1:0] extra;
    rst_n         = 1'b0;
    host_request  = '0;
    bus_done      = 1'b0;
    bus_read_data = 32'h1234_5678;
    bus_status    = 2'b11;
    randomize_hosts();

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_bus_request", 64'(bus_request), 64'd0);
    check("rst_host_done", 64'(host_done), 64'd0);
    check("rst_host_status", 64'(host_status), 64'd0);
    check("rst_read_data", 64'(host_read_data), 64'd0);
    check("rst_state", 64'(debug_state), 64'(IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // host 0 alone writes 0x0010, done in the third request cycle
    host_address[0]   = 16'h0010;
    host_direction[0] = RGGEN_WRITE;
    host_request      = 2'b01;
    do_transfer(3, 32'h0, RGGEN_OKAY, 1'b0, 1'b1);

    // both request together after reset: host 0 then host 1
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    rr_last = HOSTS - 1;
    randomize_hosts();
    host_request = 2'b11;
    do_transfer(1, $urandom, RGGEN_OKAY, 1'b0, 1'b1);
    do_transfer(2, $urandom, RGGEN_EXOKAY, 1'b0, 1'b1);

    // both continuously: alternate grants
    host_request = 2'b11;
    for (int t = 0; t < 4; t++) do_transfer($urandom_range(1, 3), $urandom, RGGEN_OKAY, 1'b0, 1'b0);
    host_request = '0;

    // read with error status passes through
    host_direction[1] = RGGEN_READ;
    host_request      = 2'b10;
    do_transfer(2, 32'hDEAD_BEEF, RGGEN_SLAVE_ERROR, 1'b0, 1'b0);

    // lone requester wins back-to-back
    do_transfer(1, $urandom, RGGEN_OKAY, 1'b0, 1'b1);

    // request dropped while granted: transfer still completes
    host_request = 2'b01;
    do_transfer(3, $urandom, RGGEN_OKAY, 1'b1, 1'b1);

`ifndef RGGEN_BUS_ARBITER_TIMEOUT_EN
    // no watchdog: a slow register block is waited for
    host_request = 2'b10;
    do_transfer(20, $urandom, RGGEN_OKAY, 1'b0, 1'b1);
`endif

    // randomized traffic against the reference model
    for (int t = 0; t < 24; t++) begin
      randomize_hosts();
      extra = HOSTS'($urandom);
      host_request = host_request | extra;
      if (host_request == '0) host_request[$urandom_range(0, HOSTS - 1)] = 1'b1;
      do_transfer($urandom_range(1, 4), $urandom, 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
    end
    host_request = '0;
    @(posedge clk); #1;

    // reset while BUSY: bus_request drops without a clock edge
    host_request = 2'b10;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_reset_bus_request", 64'(bus_request), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_bus_request", 64'(bus_request), 64'd0);
    check("async_reset_host_done", 64'(host_done), 64'd0);
    check("async_reset_state", 64'(debug_state), 64'(IDLE));
    @(posedge clk); #1;
    rst_n   = 1'b1;
    rr_last = HOSTS - 1;
    host_request = 2'b11;
    do_transfer(2, $urandom, RGGEN_OKAY, 1'b0, 1'b1);
    do_transfer(1, $urandom, RGGEN_OKAY, 1'b0, 1'b1);

`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
    // watchdog: no bus_done at all
    host_request  = 2'b01;
    bus_read_data = 32'hCAFE_F00D;
    void'(rr_pick(host_request, rr_last));
    rr_last = 0;
    n_high = 0;
    @(negedge clk);
    check("to_idle_bus_request", 64'(bus_request), 64'd0);
    for (int c = 0; c < 4 * TIMEOUT; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (bus_request) n_high++;
      if (host_done != '0) break;
    end
    check("to_cycles", 64'(n_high), 64'(TIMEOUT));
    check("to_host_done", 64'(host_done), 64'd1);
    check("to_status", 64'(host_status), 64'(RGGEN_SLAVE_ERROR));
    check("to_read_data", 64'(host_read_data), 64'd0);
    @(posedge clk); #1;
    host_request = '0;
    @(negedge clk);
    check("to_back_idle", 64'(debug_state), 64'(IDLE));
    check("to_bus_request_low", 64'(bus_request), 64'd0);
    @(posedge clk); #1;

    // bus_done on the timeout cycle keeps the real status
    host_request = 2'b10;
    do_transfer(TIMEOUT, 32'h0BAD_CAFE, RGGEN_EXOKAY, 1'b0, 1'b1);
`endif

    @(negedge clk);
    check("final_idle", 64'(debug_state), 64'(IDLE));
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
